// File: rtl/uart_rx_pair.sv
// 8N1 UART receiver that collects two back-to-back frames and presents them as one pair.
// A lone first byte is dropped after TIMEOUT_BITS idle bit-times; a bad stop bit raises Frame_Error.
module uart_rx_pair #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Parallel_1,
    output logic [7:0] Rx_Parallel_2,
    output logic       Data_Valid,
    output logic       Frame_Error,
    output logic       Pair_Timeout,
    output logic       Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t           state;
    logic             rx_p0;
    logic             rx_s;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] to_tick;
    logic [TO_W-1:0]  to_cnt;
    logic [2:0]       bit_idx;
    logic             byte_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       pend_byte;

    logic data_sample;
    logic stop_sample;
    logic store_first;

    // Stage p0 -> s: two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= Rx_Serial;
            rx_s  <= rx_p0;
        end
    end

    assign data_sample = (state == DATA) && (clk_cnt == FULL_M1);
    assign stop_sample = (state == STOP) && (clk_cnt == FULL_M1);
    assign store_first = stop_sample && rx_s && !byte_idx;

    // Data registers carry no reset; they are only observed through the validated outputs
    always_ff @(posedge clk) begin
        if (data_sample) begin
            shift_reg[bit_idx] <= rx_s;
        end
        if (store_first) begin
            pend_byte <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            to_tick       <= '0;
            to_cnt        <= '0;
            bit_idx       <= '0;
            byte_idx      <= 1'b0;
            Rx_Parallel_1 <= 8'h00;
            Rx_Parallel_2 <= 8'h00;
            Data_Valid    <= 1'b0;
            Frame_Error   <= 1'b0;
            Pair_Timeout  <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            Frame_Error  <= 1'b0;
            Pair_Timeout <= 1'b0;

            case (state)
                IDLE: begin
                    // A start edge takes priority over an expiring pair timeout
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end else if (byte_idx) begin
                        if (to_cnt == TO_MAX) begin
                            byte_idx     <= 1'b0;
                            Pair_Timeout <= 1'b1;
                        end else if (to_tick == FULL_M1) begin
                            to_tick <= '0;
                            to_cnt  <= to_cnt + 1'b1;
                        end else begin
                            to_tick <= to_tick + 1'b1;
                        end
                    end
                end

                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Returning to IDLE at mid-stop leaves half a bit to catch a zero-gap start edge
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (!byte_idx) begin
                                byte_idx <= 1'b1;
                                to_cnt   <= '0;
                                to_tick  <= '0;
                            end else begin
                                Rx_Parallel_1 <= pend_byte;
                                Rx_Parallel_2 <= shift_reg;
                                Data_Valid    <= 1'b1;
                                byte_idx      <= 1'b0;
                            end
                        end else begin
                            state       <= RECOVER;
                            Frame_Error <= 1'b1;
                            byte_idx    <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                RECOVER: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy = (state != IDLE) || byte_idx;

endmodule
